// File: rtl/alu_arbiter_pkg.sv
// Shared types for the two-requester ALU arbiter: FSM states, requester index,
// captured operation bundle and ALU operation encodings.
package alu_arbiter_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  typedef logic req_idx_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [3:0]        alu_crl;
    logic              sub;
    logic              sign;
  } alu_op_t;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_AND = 4'd1;
  localparam logic [3:0] ALU_OR  = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Alu_32bit: combinational 32-bit datapath. ADD honours sub; SLT compares
// signed or unsigned per sign. OF/CF are meaningful for ADD only (CF = borrow on sub).
module Alu_32bit
  import alu_arbiter_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  alu_crl,
  input  logic        sub,
  input  logic        sign,
  output logic [31:0] result,
  output logic        zf,
  output logic        of,
  output logic        cf
);

  logic        is_sub;
  logic [31:0] b_eff;
  logic [32:0] sum;
  logic        ovf;
  logic        lt;

  always_comb begin
    is_sub = sub || (alu_crl == ALU_SLT);
    b_eff  = is_sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + {32'd0, is_sub};
    ovf    = (a[31] == b_eff[31]) && (sum[31] != a[31]);
    // signed less-than is the difference sign corrected by overflow; unsigned is the borrow
    lt     = sign ? (sum[31] ^ ovf) : ~sum[32];

    result = '0;
    case (alu_crl)
      ALU_ADD: result = sum[31:0];
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {31'd0, lt};
      ALU_SLL: result = a << b[4:0];
      ALU_SRL: result = a >> b[4:0];
      ALU_SRA: result = $signed(a) >>> b[4:0];
      default: result = '0;
    endcase

    zf = (result == '0);
    of = (alu_crl == ALU_ADD) && ovf;
    cf = (alu_crl == ALU_ADD) && (sum[32] ^ is_sub);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared Alu_32bit (IDLE -> EXEC -> RESP).
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_alu_crl,
  input  logic        req0_sub,
  input  logic        req0_sign,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_alu_crl,
  input  logic        req1_sub,
  input  logic        req1_sign,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_zf,
  output logic        rsp0_of,
  output logic        rsp0_cf,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_zf,
  output logic        rsp1_of,
  output logic        rsp1_cf,
  output logic        busy
);

  state_t      state_q, state_d;
  alu_op_t     op_q, op_d;
  req_idx_t    op_idx_q, op_idx_d;
  logic [31:0] res_q, res_d;
  logic        zf_q, zf_d, of_q, of_d, cf_q, cf_d;
  logic        rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic        busy_q, busy_d;

  alu_op_t     req0_op, req1_op;
  req_idx_t    grant_idx, tie_winner;
  logic        accept, rsp_ready_sel;
  logic [31:0] alu_result;
  logic        alu_zf, alu_of, alu_cf;

  Alu_32bit u_alu (
    .a       (op_q.a),
    .b       (op_q.b),
    .alu_crl (op_q.alu_crl),
    .sub     (op_q.sub),
    .sign    (op_q.sign),
    .result  (alu_result),
    .zf      (alu_zf),
    .of      (alu_of),
    .cf      (alu_cf)
  );

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb tie_winner = 1'b0;
`else
  req_idx_t last_grant_q, last_grant_d;

  always_comb begin
    tie_winner   = ~last_grant_q;
    last_grant_d = accept ? grant_idx : last_grant_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end
`endif

  always_comb begin
    req0_op = '{a: req0_a, b: req0_b, alu_crl: req0_alu_crl, sub: req0_sub, sign: req0_sign};
    req1_op = '{a: req1_a, b: req1_b, alu_crl: req1_alu_crl, sub: req1_sub, sign: req1_sign};
    rsp_ready_sel = op_idx_q ? rsp1_ready : rsp0_ready;

    state_d    = state_q;
    op_d       = op_q;
    op_idx_d   = op_idx_q;
    res_d      = res_q;
    zf_d       = zf_q;
    of_d       = of_q;
    cf_d       = cf_q;
    grant_idx  = 1'b0;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    case (state_q)
      IDLE: begin
        // readies are combinational, so they are also held low while rst is asserted
        if (!rst && (req0_valid || req1_valid)) begin
          accept     = 1'b1;
          grant_idx  = (req0_valid && req1_valid) ? tie_winner : req1_valid;
          req0_ready = ~grant_idx;
          req1_ready = grant_idx;
          op_idx_d   = grant_idx;
          op_d       = grant_idx ? req1_op : req0_op;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_result;
        zf_d    = alu_zf;
        of_d    = alu_of;
        cf_d    = alu_cf;
        state_d = RESP;
      end
      RESP: if (rsp_ready_sel) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rsp0_valid_d = (state_d == RESP) && (op_idx_d == 1'b0);
    rsp1_valid_d = (state_d == RESP) && (op_idx_d == 1'b1);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= '0;
      op_idx_q     <= 1'b0;
      res_q        <= '0;
      zf_q         <= 1'b0;
      of_q         <= 1'b0;
      cf_q         <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      op_idx_q     <= op_idx_d;
      res_q        <= res_d;
      zf_q         <= zf_d;
      of_q         <= of_d;
      cf_q         <= cf_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    rsp0_valid  = rsp0_valid_q;
    rsp1_valid  = rsp1_valid_q;
    busy        = busy_q;
    rsp0_result = rsp0_valid_q ? res_q : '0;
    rsp0_zf     = rsp0_valid_q & zf_q;
    rsp0_of     = rsp0_valid_q & of_q;
    rsp0_cf     = rsp0_valid_q & cf_q;
    rsp1_result = rsp1_valid_q ? res_q : '0;
    rsp1_zf     = rsp1_valid_q & zf_q;
    rsp1_of     = rsp1_valid_q & of_q;
    rsp1_cf     = rsp1_valid_q & cf_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized rounds
// checked against an arithmetic reference model and a grant-order model.
module tb_alu_arbiter;

  typedef struct packed {
    logic [31:0] r;
    logic        zf;
    logic        of;
    logic        cf;
  } exp_t;

  localparam longint SMAX = 2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld[2];
  logic        rdy[2];
  logic [31:0] a_in[2];
  logic [31:0] b_in[2];
  logic [3:0]  op_in[2];
  logic        sub_in[2];
  logic        sign_in[2];
  logic        rsp_vld[2];
  logic        rsp_rdy[2];
  logic [31:0] rsp_res[2];
  logic        rsp_zf[2];
  logic        rsp_of[2];
  logic        rsp_cf[2];
  logic        busy;

  int checks = 0;
  int errors = 0;
  int last_g = 1;
  int g;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (vld[0]),
    .req0_ready   (rdy[0]),
    .req0_a       (a_in[0]),
    .req0_b       (b_in[0]),
    .req0_alu_crl (op_in[0]),
    .req0_sub     (sub_in[0]),
    .req0_sign    (sign_in[0]),
    .req1_valid   (vld[1]),
    .req1_ready   (rdy[1]),
    .req1_a       (a_in[1]),
    .req1_b       (b_in[1]),
    .req1_alu_crl (op_in[1]),
    .req1_sub     (sub_in[1]),
    .req1_sign    (sign_in[1]),
    .rsp0_valid   (rsp_vld[0]),
    .rsp0_ready   (rsp_rdy[0]),
    .rsp0_result  (rsp_res[0]),
    .rsp0_zf      (rsp_zf[0]),
    .rsp0_of      (rsp_of[0]),
    .rsp0_cf      (rsp_cf[0]),
    .rsp1_valid   (rsp_vld[1]),
    .rsp1_ready   (rsp_rdy[1]),
    .rsp1_result  (rsp_res[1]),
    .rsp1_zf      (rsp_zf[1]),
    .rsp1_of      (rsp_of[1]),
    .rsp1_cf      (rsp_cf[1]),
    .busy         (busy)
  );

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] op, input logic sub, input logic sign);
    exp_t            e;
    longint          sa, sb, s;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    e  = '0;
    case (op)
      4'd0: begin
        if (sub) begin
          s    = sa - sb;
          e.r  = a - b;
          e.cf = (ua < ub);
        end else begin
          s    = sa + sb;
          e.r  = a + b;
          e.cf = (ua + ub) > 64'hFFFF_FFFF;
        end
        e.of = (s > SMAX) || (s < SMIN);
      end
      4'd1: e.r = a & b;
      4'd2: e.r = a | b;
      4'd3: e.r = a ^ b;
      4'd4: e.r = sign ? {31'd0, (sa < sb)} : {31'd0, (ua < ub)};
      4'd5: e.r = a << b[4:0];
      4'd6: e.r = a >> b[4:0];
      4'd7: e.r = 32'($signed(a) >>> b[4:0]);
      default: e.r = '0;
    endcase
    e.zf = (e.r == 32'd0);
    return e;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic sub, input logic sign);
    a_in[r] = a; b_in[r] = b; op_in[r] = op; sub_in[r] = sub; sign_in[r] = sign;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_req(input int r);
    set_req(r, rand_operand(), rand_operand(), 4'($urandom_range(0, 9)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Entered just after a rising edge with the DUT idle; returns at the same phase.
  task automatic round(input logic v0, input logic v1, input int hold, output int gnt);
    int   w;
    exp_t e;
    vld[0] = v0;
    vld[1] = v1;
    @(negedge clk);
    if (!v0 && !v1) begin
      chk1("idle_rdy0", rdy[0], 1'b0);
      chk1("idle_rdy1", rdy[1], 1'b0);
      chk1("idle_busy", busy, 1'b0);
      gnt = -1;
      @(posedge clk); #1;
      return;
    end
`ifdef ALU_ARB_FIXED_PRIO_EN
    w = v0 ? 0 : 1;
`else
    w = (v0 && v1) ? (1 - last_g) : (v0 ? 0 : 1);
`endif
    gnt = rdy[1] ? 1 : 0;
    chk1("accept_rdy0", rdy[0], w == 0);
    chk1("accept_rdy1", rdy[1], w == 1);
    e = model(a_in[w], b_in[w], op_in[w], sub_in[w], sign_in[w]);
    last_g = w;
    @(posedge clk); #1;
    vld[w] = 1'b0;
    @(negedge clk);
    chk1("exec_busy", busy, 1'b1);
    chk1("exec_rsp0_valid", rsp_vld[0], 1'b0);
    chk1("exec_rsp1_valid", rsp_vld[1], 1'b0);
    chk1("exec_rdy0", rdy[0], 1'b0);
    chk1("exec_rdy1", rdy[1], 1'b0);
    for (int k = 0; k <= hold; k++) begin
      @(posedge clk); #1;
      rsp_rdy[w]     = (k == hold);
      rsp_rdy[1 - w] = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk1("resp_valid", rsp_vld[w], 1'b1);
      chk1("resp_other_valid", rsp_vld[1 - w], 1'b0);
      chk32("resp_result", rsp_res[w], e.r);
      chk32("resp_flags", {29'd0, rsp_zf[w], rsp_of[w], rsp_cf[w]}, {29'd0, e.zf, e.of, e.cf});
      chk32("resp_other_zero", {rsp_res[1 - w], rsp_zf[1 - w], rsp_of[1 - w], rsp_cf[1 - w]}, 35'd0);
      chk1("resp_busy", busy, 1'b1);
      chk1("resp_rdy0", rdy[0], 1'b0);
      chk1("resp_rdy1", rdy[1], 1'b0);
    end
    @(posedge clk); #1;
    rsp_rdy[0] = 1'b0;
    rsp_rdy[1] = 1'b0;
  endtask

  task automatic reset_in_exec();
    rand_req(0);
    vld[0] = 1'b1;
    vld[1] = 1'b0;
    @(negedge clk);
    chk1("rx_accept", rdy[0], 1'b1);
    @(posedge clk); #1;
    vld[0] = 1'b0;
    @(negedge clk);
    chk1("rx_exec_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk1("rx_busy", busy, 1'b0);
    chk1("rx_rsp0_valid", rsp_vld[0], 1'b0);
    chk1("rx_rsp1_valid", rsp_vld[1], 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_g = 1;
    repeat (3) begin
      @(negedge clk);
      chk1("rx_after_rsp0", rsp_vld[0], 1'b0);
      chk1("rx_after_rsp1", rsp_vld[1], 1'b0);
      chk1("rx_after_busy", busy, 1'b0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int order[4];
    logic v0, v1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    order = '{0, 0, 0, 0};
`else
    order = '{0, 1, 0, 1};
`endif
    rst = 1'b1;
    for (int r = 0; r < 2; r++) begin
      vld[r] = 1'b0; rsp_rdy[r] = 1'b0;
      set_req(r, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
    end
    vld[0] = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_rdy0", rdy[0], 1'b0);
    chk1("rst_rdy1", rdy[1], 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_rsp0_valid", rsp_vld[0], 1'b0);
    chk1("rst_rsp1_valid", rsp_vld[1], 1'b0);
    chk32("rst_rsp0_result", rsp_res[0], 32'd0);
    chk32("rst_rsp1_result", rsp_res[1], 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    set_req(0, 32'd5, 32'd7, 4'd0, 1'b0, 1'b0);
    round(1'b1, 1'b0, 0, g);
    chk32("add_5_7_grant", g, 0);

    reset_in_exec();

    set_req(0, 32'd1, 32'd1, 4'd0, 1'b1, 1'b0);
    set_req(1, 32'd1, 32'd1, 4'd0, 1'b1, 1'b0);
    round(1'b1, 1'b1, 0, g);
    chk32("tie_after_reset_grant", g, 0);
    rand_req(0);
`ifdef ALU_ARB_FIXED_PRIO_EN
    round(1'b0, 1'b1, 5, g);
`else
    round(1'b1, 1'b1, 5, g);
`endif
    chk32("req1_second_grant", g, 1);
    vld[0] = 1'b0;

    reset_in_exec();
    for (int i = 0; i < 4; i++) begin
      rand_req(0);
      rand_req(1);
      round(1'b1, 1'b1, 0, g);
      chk32($sformatf("tie_order_%0d", i), g, order[i]);
    end
    vld[0] = 1'b0;
    vld[1] = 1'b0;

    set_req(0, 32'h7FFF_FFFF, 32'd1, 4'd0, 1'b0, 1'b0);
    round(1'b1, 1'b0, 0, g);

    for (int i = 0; i < 40; i++) begin
      for (int r = 0; r < 2; r++) if (!vld[r]) rand_req(r);
      v0 = vld[0] | 1'($urandom_range(0, 1));
      v1 = vld[1] | 1'($urandom_range(0, 1));
      round(v0, v1, $urandom_range(0, 2), g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have no parameters; data width is fixed at 32 and requester count at 2; n below denotes requester index 0 or 1.
REQ-002 SHALL have port clk, input, 1: single clock, rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port reqn_valid, input, 1: requester n presents an operation.
REQ-005 SHALL have port reqn_ready, output, 1: operation of requester n accepted this cycle.
REQ-006 SHALL have ports reqn_a and reqn_b, input, 32 each: operands.
REQ-007 SHALL have port reqn_alu_crl, input, 4: ALU operation select.
REQ-008 SHALL have ports reqn_sub and reqn_sign, input, 1 each: subtract select and signed-compare select.
REQ-009 SHALL have port rspn_valid, output, 1: result for requester n available.
REQ-010 SHALL have port rspn_ready, input, 1: requester n consumes the result.
REQ-011 SHALL have port rspn_result, output, 32: ALU result.
REQ-012 SHALL have ports rspn_zf, rspn_of and rspn_cf, output, 1 each: zero, overflow and carry flags.
REQ-013 SHALL have port busy, output, 1: high when the FSM is not in IDLE.

Function
REQ-014 SHALL implement an FSM with states IDLE, EXEC and RESP.
REQ-015 IDLE: when any reqn_valid is high, SHALL grant one requester, assert its reqn_ready combinationally in that cycle, register its a, b, alu_crl, sub, sign and n into op registers, and move to EXEC.
REQ-016 IDLE SHALL assert no reqn_ready when no valid is present; the FSM stays in IDLE.
REQ-017 reqn_ready SHALL never be high outside IDLE, and never high for both requesters in the same cycle.
REQ-018 EXEC: the shared ALU SHALL be driven only from the op registers; result and ZF/OF/CF SHALL be captured into response registers at the end of the cycle; next state RESP.
REQ-019 RESP: the granted rspn_valid SHALL be high; the other rsp valid SHALL be low.
REQ-020 rspn_result and the flags SHALL be held stable while rspn_valid=1 and rspn_ready=0.
REQ-021 RESP with rspn_ready=1 SHALL return to IDLE; no new request is accepted in that same cycle.
REQ-022 Latency: request accepted at edge T SHALL give rsp_valid high from cycle T+2; minimum issue interval 3 cycles.
REQ-023 Both valid in IDLE: the requester not granted last SHALL win (round-robin); last_grant SHALL update on every accept.
REQ-024 Requesters keep valid and data stable until ready; reqn_valid dropping before ready SHALL cancel with no effect.
REQ-025 rspn_* outputs of the non-granted requester SHALL be 0 for result and all flags.

Reset
REQ-026 rst SHALL force IDLE, last_grant=1 (requester 0 wins the first tie), op and response registers 0, all reqn_ready, rspn_valid and busy 0.
REQ-027 rst asserted in EXEC or RESP SHALL discard the in-flight operation with no response delivered.

Configuration
REQ-028 Macro ALU_ARB_FIXED_PRIO_EN defined: requester 0 SHALL always win a tie, and last_grant is unused.
REQ-029 Macro ALU_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-023.

Structure
REQ-030 Shared package SHALL hold the FSM state enum (IDLE/EXEC/RESP), the requester-index type and the ALU op-bundle struct (a, b, alu_crl, sub, sign).
REQ-031 SHALL instantiate exactly one sub-module, the existing Alu_32bit datapath; arbitration and FSM logic are inline.

Verification
REQ-032 After reset, req0 add 5+7 (sub=0) -> req0_ready at T, rsp0_valid at T+2, result 12, ZF=0.
REQ-033 Both valid at T, both 1-1 with sub=1 -> req0 served first with result 0 and ZF=1; req1 then accepted in the first IDLE cycle after rsp0 handshake.
REQ-034 Back-to-back ties x4 -> grant order 0,1,0,1; with ALU_ARB_FIXED_PRIO_EN -> 0,0,0,0 while req0 stays valid.
REQ-035 rsp1_ready held low 5 cycles -> rsp1_valid and result stable for 5 cycles, no new accept, busy=1.
REQ-036 rst pulsed during EXEC -> no rsp valid afterwards, busy=0, next tie won by req0.
REQ-037 0x7FFFFFFF+1 -> result 0x80000000, OF=1, CF=0.
